// File: rtl/dot_prod_pkg.sv
// Shared widths, FSM encoding and Q-format helpers for the dot_prod feeder.
// Optional watchdog default lives here for DOTPROD_FEEDER_TIMEOUT_EN builds.
package dot_prod_pkg;

  localparam int unsigned NROW               = 16;
  localparam int unsigned DEF_NCOL           = 8;
  localparam int unsigned QN                 = 6;
  localparam int unsigned QM                 = 11;
  localparam int unsigned BITWIDTH           = QN + QM + 1;
  localparam int unsigned MEMORY_BITWIDTH    = BITWIDTH * NROW;
  localparam int unsigned ADDR_BITWIDTH      = $clog2(DEF_NCOL);
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef logic signed [BITWIDTH-1:0] q_elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } feeder_state_e;

  localparam q_elem_t Q_ONE = BITWIDTH'(1 << QM);

  function automatic q_elem_t q_from_int(input int v);
    return BITWIDTH'(v <<< QM);
  endfunction

  // Fixed-point multiply, result truncated back to element width
  function automatic q_elem_t q_mul(input q_elem_t a, input q_elem_t b);
    logic signed [2*BITWIDTH-1:0] p;
    p = a * b;
    return BITWIDTH'(p >>> QM);
  endfunction

endpackage

// File: rtl/dot_prod_feeder_if.sv
// Load, run-control, column-fetch and result signals between the feeder and its environment.
interface dot_prod_feeder_if;
  import dot_prod_pkg::*;

  logic                       load_valid;
  logic                       load_ready;
  logic                       load_is_input;
  logic [ADDR_BITWIDTH-1:0]   load_addr;
  logic [MEMORY_BITWIDTH-1:0] load_data;
  logic                       start;
  logic                       busy;
  logic                       dp_reset;
  logic [ADDR_BITWIDTH-1:0]   colAddress;
  logic [MEMORY_BITWIDTH-1:0] weightMemOutput;
  logic [BITWIDTH-1:0]        inputVec;
  logic                       dataReady;
  logic [MEMORY_BITWIDTH-1:0] outputVec;
  logic                       result_valid;
  logic                       result_ready;
  logic [MEMORY_BITWIDTH-1:0] result_data;
  logic                       result_err;

  modport slave (
    input  load_valid, load_is_input, load_addr, load_data, start,
    input  colAddress, dataReady, outputVec, result_ready,
    output load_ready, busy, dp_reset, weightMemOutput, inputVec,
    output result_valid, result_data, result_err
  );

  modport master (
    output load_valid, load_is_input, load_addr, load_data, start,
    output colAddress, dataReady, outputVec, result_ready,
    input  load_ready, busy, dp_reset, weightMemOutput, inputVec,
    input  result_valid, result_data, result_err
  );

endinterface

// File: rtl/feeder_ram.sv
// Single write port, registered read port; out-of-range addresses write nothing and read 0.
module feeder_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 18,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (32'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dot_prod_feeder.sv
// Responder for dot_prod column fetches: weight/input stores, run sequencing, result capture.
// DOTPROD_FEEDER_TIMEOUT_EN adds a RUN watchdog that ends the run with result_err=1.
module dot_prod_feeder
  import dot_prod_pkg::*;
#(
  parameter int unsigned NCOL = DEF_NCOL
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic            clock,
  input  logic            reset,
  dot_prod_feeder_if.slave bus
);

  feeder_state_e              state_q, state_d;
  logic                       rst_cnt_q, rst_cnt_d;
  logic                       load_ready_q, busy_q, dp_reset_q, result_valid_q, data_ready_q;
  logic [MEMORY_BITWIDTH-1:0] result_data_q, result_data_d;
  logic                       load_fire_c, dr_rise_c;

`ifdef DOTPROD_FEEDER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             result_err_q, result_err_d;
`endif

  assign load_fire_c = bus.load_valid & load_ready_q;
  assign dr_rise_c   = bus.dataReady & ~data_ready_q;

  feeder_ram #(.DEPTH(NCOL), .WIDTH(MEMORY_BITWIDTH), .AW(ADDR_BITWIDTH)) u_w_ram (
    .clk     (clock),
    .rst_n   (reset),
    .we_i    (load_fire_c & ~bus.load_is_input),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (bus.colAddress),
    .rdata_o (bus.weightMemOutput)
  );

  feeder_ram #(.DEPTH(NCOL), .WIDTH(BITWIDTH), .AW(ADDR_BITWIDTH)) u_x_ram (
    .clk     (clock),
    .rst_n   (reset),
    .we_i    (load_fire_c & bus.load_is_input),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data[BITWIDTH-1:0]),
    .raddr_i (bus.colAddress),
    .rdata_o (bus.inputVec)
  );

  // Next-state: RST lasts two cycles, RUN waits for a dataReady rise seen inside RUN
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    result_data_d = result_data_q;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    result_err_d  = result_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RST;
          rst_cnt_d = 1'b0;
        end
      end
      RST: begin
        if (rst_cnt_q) begin
          state_d = RUN;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      RUN: begin
        if (dr_rise_c) begin
          state_d       = HOLD;
          result_data_d = bus.outputVec;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
          result_err_d  = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = HOLD;
          result_data_d = '0;
          result_err_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
      end
      HOLD: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from state_d so they line up with state_q
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rst_cnt_q      <= 1'b0;
      load_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      dp_reset_q     <= 1'b1;
      result_valid_q <= 1'b0;
      data_ready_q   <= 1'b0;
      result_data_q  <= '0;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      result_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      load_ready_q   <= (state_d == IDLE);
      busy_q         <= (state_d != IDLE);
      dp_reset_q     <= (state_d != RUN);
      result_valid_q <= (state_d == HOLD);
      data_ready_q   <= bus.dataReady;
      result_data_q  <= result_data_d;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      result_err_q   <= result_err_d;
`endif
    end
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.busy         = busy_q;
  assign bus.dp_reset     = dp_reset_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
  assign bus.result_err   = result_err_q;
`else
  assign bus.result_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Bench for dot_prod_feeder with a behavioural dot_prod driver and a result scoreboard.
// Build with DOTPROD_FEEDER_TIMEOUT_EN to exercise the RUN watchdog.
module tb_dot_prod_feeder;
  import dot_prod_pkg::*;

  localparam int unsigned TB_NCOL = 6;
  localparam int unsigned BW      = BITWIDTH;
  localparam int unsigned MW      = MEMORY_BITWIDTH;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`endif

  typedef struct {
    logic [MW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [MW-1:0] w_shadow [8];
  logic [BW-1:0] x_shadow [8];
  exp_t          sb_q [$];

  dot_prod_feeder_if bus_if ();

  dot_prod_feeder #(
    .NCOL(TB_NCOL)
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TB_TIMEOUT)
`endif
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accumulate one column into a row vector in Q(QN.QM) with element-width wrap
  function automatic logic [MW-1:0] mac_col(input logic [MW-1:0] acc, input logic [MW-1:0] w,
                                           input logic [BW-1:0] x);
    logic [MW-1:0]          r;
    logic signed [BW-1:0]   a, wv, xv;
    logic signed [2*BW-1:0] p;
    r = acc;
    for (int row = 0; row < int'(NROW); row++) begin
      a  = r[row*BW +: BW];
      wv = w[row*BW +: BW];
      xv = x;
      p  = wv * xv;
      a  = a + BW'(p >>> QM);
      r[row*BW +: BW] = a;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] expected_result();
    logic [MW-1:0] r;
    r = '0;
    for (int c = 0; c < int'(TB_NCOL); c++) r = mac_col(r, w_shadow[c], x_shadow[c]);
    return r;
  endfunction

  task automatic load_word(input logic is_in, input logic [ADDR_BITWIDTH-1:0] a, input logic [MW-1:0] d);
    @(negedge clk);
    bus_if.load_valid    = 1'b1;
    bus_if.load_is_input = is_in;
    bus_if.load_addr     = a;
    bus_if.load_data     = d;
    @(posedge clk);
    #1;
    bus_if.load_valid = 1'b0;
    if (32'(a) < TB_NCOL) begin
      if (is_in) x_shadow[a] = d[BW-1:0];
      else       w_shadow[a] = d;
    end
  endtask

  function automatic logic [MW-1:0] rand_col();
    logic [MW-1:0] r;
    for (int i = 0; i < int'(NROW); i++) r[i*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  // Pulse start (optionally with a load) and wait for dp_reset to drop
  task automatic launch(input bit with_load);
    int n;
    logic [MW-1:0] d;
    d = rand_col();
    @(negedge clk);
    bus_if.start = 1'b1;
    if (with_load) begin
      bus_if.load_valid    = 1'b1;
      bus_if.load_is_input = 1'b0;
      bus_if.load_addr     = 3'd2;
      bus_if.load_data     = d;
    end
    @(posedge clk);
    #1;
    bus_if.start      = 1'b0;
    bus_if.load_valid = 1'b0;
    if (with_load) w_shadow[2] = d;
    check_eq("busy_after_start", MW'(bus_if.busy), MW'(1));
    n = 0;
    while (bus_if.dp_reset === 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("dp_reset_cycles", MW'(n), MW'(2));
  endtask

  task automatic do_run(input int hold, input bit pre_high, input bit with_load);
    int n;
    logic [MW-1:0] acc;
    exp_t e;
    if (pre_high) bus_if.dataReady = 1'b1;
    launch(with_load);
    sb_q.push_back('{data: expected_result(), err: 1'b0});
    if (pre_high) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      check_eq("stale_dataReady_ignored", MW'(bus_if.result_valid), MW'(0));
      bus_if.dataReady = 1'b0;
    end
    acc = '0;
    for (int c = 0; c < int'(TB_NCOL); c++) begin
      bus_if.colAddress = ADDR_BITWIDTH'(c);
      @(posedge clk);
      #1;
      acc = mac_col(acc, bus_if.weightMemOutput, bus_if.inputVec);
    end
    bus_if.outputVec = acc;
    bus_if.dataReady = 1'b1;
    n = 0;
    while (bus_if.result_valid !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("result_valid_rise", MW'(bus_if.result_valid), MW'(1));
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", MW'(0), MW'(1));
      e = '{data: '0, err: 1'b0};
    end else begin
      e = sb_q.pop_front();
    end
    check_eq("result_data", bus_if.result_data, e.data);
    check_eq("result_err", MW'(bus_if.result_err), MW'(e.err));
    bus_if.outputVec = rand_col();
    for (int i = 0; i < hold; i++) begin
      bus_if.start         = (i == 2);
      bus_if.load_valid    = (i == 4);
      bus_if.load_is_input = 1'b0;
      bus_if.load_addr     = 3'd1;
      bus_if.load_data     = ~w_shadow[1];
      @(posedge clk);
      #1;
      if (i == 4) check_eq("hold_load_ready", MW'(bus_if.load_ready), MW'(0));
      if (i == hold - 1) begin
        check_eq("hold_valid", MW'(bus_if.result_valid), MW'(1));
        check_eq("hold_data", bus_if.result_data, e.data);
      end
    end
    bus_if.start      = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.dataReady  = 1'b0;
    bus_if.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.result_ready = 1'b0;
    check_eq("idle_after_accept", MW'({bus_if.busy, bus_if.result_valid, bus_if.load_ready}), MW'(3'b001));
    if (hold > 0) begin
      @(posedge clk);
      #1;
      check_eq("start_not_queued", MW'(bus_if.busy), MW'(0));
    end
  endtask

  initial begin
    int n;
    logic [MW-1:0] ones, d0;
    exp_t e;
    reset                = 1'b0;
    bus_if.load_valid    = 1'b0;
    bus_if.load_is_input = 1'b0;
    bus_if.load_addr     = '0;
    bus_if.load_data     = '0;
    bus_if.start         = 1'b0;
    bus_if.colAddress    = '0;
    bus_if.dataReady     = 1'b0;
    bus_if.outputVec     = '0;
    bus_if.result_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             MW'({bus_if.dp_reset, bus_if.result_valid, bus_if.load_ready, bus_if.busy, bus_if.result_err}),
             MW'(5'b10000));
    check_eq("reset_wmem", bus_if.weightMemOutput, '0);
    check_eq("reset_result_data", bus_if.result_data, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("load_ready_after_reset", MW'(bus_if.load_ready), MW'(1));

    // All-ones (1.0) weights and inputs, plus out-of-range loads that must be dropped
    for (int i = 0; i < int'(NROW); i++) ones[i*BW +: BW] = Q_ONE;
    for (int c = 0; c < int'(TB_NCOL); c++) begin
      load_word(1'b0, ADDR_BITWIDTH'(c), ones);
      load_word(1'b1, ADDR_BITWIDTH'(c), MW'(Q_ONE));
    end
    load_word(1'b0, 3'd7, ~ones);
    load_word(1'b1, 3'd6, ~ones);
    do_run(0, 1'b0, 1'b0);
    d0 = MW'(bus_if.result_data[BW-1:0]);
    check_eq("ones_row0", d0, MW'(18'h03000));

    // Read latency and out-of-range reads
    load_word(1'b0, 3'd5, rand_col());
    load_word(1'b1, 3'd5, rand_col());
    load_word(1'b0, 3'd0, rand_col());
    bus_if.colAddress = 3'd0;
    @(posedge clk);
    #1;
    bus_if.colAddress = 3'd5;
    #1;
    check_eq("read_not_early", bus_if.weightMemOutput, w_shadow[0]);
    @(posedge clk);
    #1;
    check_eq("read_w5", bus_if.weightMemOutput, w_shadow[5]);
    check_eq("read_x5", MW'(bus_if.inputVec), MW'(x_shadow[5]));
    bus_if.colAddress = 3'd7;
    @(posedge clk);
    #1;
    check_eq("read_oor7", {bus_if.weightMemOutput[MW-BW-1:0], bus_if.inputVec}, '0);
    bus_if.colAddress = 3'd6;
    @(posedge clk);
    #1;
    check_eq("read_oor6_w", bus_if.weightMemOutput, '0);

    // Random data: backpressure, stale dataReady, start-with-load
    for (int c = 0; c < int'(TB_NCOL); c++) begin
      load_word(1'b0, ADDR_BITWIDTH'(c), rand_col());
      load_word(1'b1, ADDR_BITWIDTH'(c), rand_col());
    end
    do_run(10, 1'b0, 1'b0);
    do_run(0, 1'b1, 1'b0);
    do_run(0, 1'b0, 1'b1);

    // Mid-run reset after 3 RUN cycles, then a clean run
    launch(1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check_eq("abort_outputs",
             MW'({bus_if.busy, bus_if.dp_reset, bus_if.result_valid, bus_if.load_ready}), MW'(4'b0100));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_run(0, 1'b0, 1'b0);

    // dataReady never rises
    bus_if.colAddress = '0;
    launch(1'b0);
    n = 0;
    while (bus_if.result_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
    sb_q.push_back('{data: '0, err: 1'b1});
    check_eq("timeout_cycles", MW'(n), MW'(TB_TIMEOUT));
    e = sb_q.pop_front();
    check_eq("timeout_data", bus_if.result_data, e.data);
    check_eq("timeout_err", MW'(bus_if.result_err), MW'(e.err));
    bus_if.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.result_ready = 1'b0;
    check_eq("timeout_idle", MW'(bus_if.busy), MW'(0));
`else
    check_eq("no_timeout_busy", MW'({bus_if.busy, bus_if.result_valid}), MW'(2'b10));
    reset = 1'b0;
    #1;
    check_eq("no_timeout_abort", MW'(bus_if.busy), MW'(0));
    @(negedge clk);
    reset = 1'b1;
    e = '{data: '0, err: 1'b0};
`endif
    check_eq("scoreboard_drained", MW'(sb_q.size()), MW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
